decode_pipe_stage: RTL and testbench

DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

---
 rtl/decode_pipe_stage.sv | 235 +++++++++++++++++++++++
 tb/tb_decode_pipe_stage.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe_stage.sv
// -----------------------------------------------------------------------------
// decode_pipe_stage
//   Decode stage between fetch and execute. It reads register operands, stalls
//   on a load-use hazard, resolves branches and jumps (BEQ, BNE, J, JAL, JR),
//   raises a one-cycle redirect to fetch for taken control flow, and buffers
//   decoded instructions in a small circular queue toward execute.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid / in_ready      fetch-side handshake
//   in_pc, in_instr          fetched instruction and its PC
//   rs, rt                   register-file read addresses (combinational)
//   a_gpr, b_gpr             register-file data for rs / rt
//   ld_busy, ld_rd           in-flight load and its destination register
//   flush                    synchronous pipeline clear
//   out_valid / out_ready    execute-side handshake
//   out_pc/instr/a/b         head queue entry
//   redirect_valid/pc        registered branch redirect to fetch
//   occupancy                number of queued entries
// -----------------------------------------------------------------------------
module decode_pipe_stage #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 2,
    parameter int DELAY_SLOT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [31:0]                in_instr,
    output logic [4:0]                 rs,
    output logic [4:0]                 rt,
    input  logic [XLEN-1:0]            a_gpr,
    input  logic [XLEN-1:0]            b_gpr,
    input  logic                       ld_busy,
    input  logic [4:0]                 ld_rd,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_instr,
    output logic [XLEN-1:0]            out_a,
    output logic [XLEN-1:0]            out_b,
    output logic                       redirect_valid,
    output logic [XLEN-1:0]            redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [OCC_W-1:0] DEPTH_OCC    = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR     = PTR_W'(DEPTH - 1);
    localparam logic             DISCARD_SLOT = (DELAY_SLOT == 0);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FN_JR      = 6'b001000;

    // Circular-pointer advance that wraps at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            ptr_inc = {PTR_W{1'b0}};
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    // Queue storage and control state
    logic [XLEN-1:0]  pc_mem_q    [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];
    logic [XLEN-1:0]  a_mem_q     [DEPTH];
    logic [XLEN-1:0]  b_mem_q     [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;

    // Combinational decode results
    logic            hazard_s;
    logic            full_s;
    logic            accept_s;
    logic            discard_s;
    logic            push_s;
    logic            pop_s;
    logic            taken_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] pc4_s;
    logic [XLEN-1:0] br_off_s;
    logic [XLEN-1:0] j_tgt_s;
    logic [5:0]      opcode_s;
    logic [5:0]      funct_s;

    assign rs       = in_instr[25:21];
    assign rt       = in_instr[20:16];
    assign opcode_s = in_instr[31:26];
    assign funct_s  = in_instr[5:0];

    // Handshake: stall on a load-use hazard or a full queue; flush wins over push/pop.
    always_comb begin
        hazard_s  = in_valid && ld_busy && (ld_rd != 5'd0) && ((ld_rd == rs) || (ld_rd == rt));
        full_s    = (occ_q == DEPTH_OCC);
        in_ready  = !full_s && !hazard_s;
        accept_s  = in_valid && in_ready;
        // Without a delay slot, the instruction fetched right behind a taken
        // branch is on the wrong path: take it off the bus but drop it.
        discard_s = DISCARD_SLOT && redirect_valid_q && accept_s;
        push_s    = accept_s && !discard_s && !flush;
        pop_s     = out_valid && out_ready && !flush;
    end

    // Branch/jump resolution; all PC arithmetic wraps modulo 2^XLEN.
    always_comb begin
        pc4_s    = in_pc + XLEN'(32'd4);
        br_off_s = {{(XLEN-18){in_instr[15]}}, in_instr[15:0], 2'b00};
        j_tgt_s  = {pc4_s[XLEN-1:28], in_instr[25:0], 2'b00};
        taken_s  = 1'b0;
        target_s = pc4_s + br_off_s;
        case (opcode_s)
            OP_BEQ: begin
                taken_s  = (a_gpr == b_gpr);
                target_s = pc4_s + br_off_s;
            end
            OP_BNE: begin
                taken_s  = (a_gpr != b_gpr);
                target_s = pc4_s + br_off_s;
            end
            OP_J, OP_JAL: begin
                taken_s  = 1'b1;
                target_s = j_tgt_s;
            end
            OP_SPECIAL: begin
                if (funct_s == FN_JR) begin
                    taken_s  = 1'b1;
                    target_s = a_gpr;
                end else begin
                    taken_s  = 1'b0;
                    target_s = pc4_s + br_off_s;
                end
            end
            default: begin
                taken_s  = 1'b0;
                target_s = pc4_s + br_off_s;
            end
        endcase
    end

    // Next-state for pointers, occupancy and redirect.
    always_comb begin
        head_d           = head_q;
        tail_d           = tail_q;
        occ_d            = occ_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        if (flush) begin
            head_d           = {PTR_W{1'b0}};
            tail_d           = {PTR_W{1'b0}};
            occ_d            = {OCC_W{1'b0}};
            redirect_valid_d = 1'b0;
        end else begin
            if (push_s) begin
                tail_d = ptr_inc(tail_q);
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = ptr_inc(head_q);
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
            // A taken branch is still enqueued; the redirect fires only for it.
            if (push_s && taken_s) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = target_s;
            end else begin
                redirect_valid_d = 1'b0;
                redirect_pc_d    = redirect_pc_q;
            end
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q           <= {PTR_W{1'b0}};
            tail_q           <= {PTR_W{1'b0}};
            occ_q            <= {OCC_W{1'b0}};
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= {XLEN{1'b0}};
        end else begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            occ_q            <= occ_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // Queue storage; cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= {XLEN{1'b0}};
                instr_mem_q[i] <= 32'd0;
                a_mem_q[i]     <= {XLEN{1'b0}};
                b_mem_q[i]     <= {XLEN{1'b0}};
            end
        end else if (push_s) begin
            pc_mem_q[tail_q]    <= in_pc;
            instr_mem_q[tail_q] <= in_instr;
            a_mem_q[tail_q]     <= a_gpr;
            b_mem_q[tail_q]     <= b_gpr;
        end
    end

    assign occupancy      = occ_q;
    assign out_valid      = (occ_q != {OCC_W{1'b0}});
    assign out_pc         = pc_mem_q[head_q];
    assign out_instr      = instr_mem_q[head_q];
    assign out_a          = a_mem_q[head_q];
    assign out_b          = b_mem_q[head_q];
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_pipe_stage
//   Two instances share all inputs: index 0 keeps the delay slot, index 1
//   discards it. A queue-based reference model predicts handshakes, occupancy
//   and redirects; a separate negedge monitor pops the expected entries and
//   compares them with the head of each DUT whenever it pops.
// -----------------------------------------------------------------------------
module tb_decode_pipe_stage;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = 32'd0;
    logic [31:0] in_instr = 32'd0;
    logic [31:0] a_gpr = 32'd0;
    logic [31:0] b_gpr = 32'd0;
    logic        ld_busy = 1'b0;
    logic [4:0]  ld_rd = 5'd0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic [1:0]  in_ready_w;
    logic [1:0]  out_valid_w;
    logic [1:0]  rv_w;
    logic [4:0]  rs_w [2];
    logic [4:0]  rt_w [2];
    logic [31:0] out_pc_w [2];
    logic [31:0] out_instr_w [2];
    logic [31:0] out_a_w [2];
    logic [31:0] out_b_w [2];
    logic [31:0] rpc_w [2];
    logic [1:0]  occ_w [2];

    int n_checks = 0;
    int n_err = 0;

    int          m_occ [2];
    bit          m_rv [2];
    logic [31:0] m_rpc [2];
    ent_t        sb0 [$];
    ent_t        sb1 [$];

    always #5 clk = ~clk;

    decode_pipe_stage #(.XLEN(32), .DEPTH(DEPTH), .DELAY_SLOT(1)) u_ds1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .in_pc(in_pc), .in_instr(in_instr), .rs(rs_w[0]), .rt(rt_w[0]),
        .a_gpr(a_gpr), .b_gpr(b_gpr), .ld_busy(ld_busy), .ld_rd(ld_rd), .flush(flush),
        .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_pc(out_pc_w[0]),
        .out_instr(out_instr_w[0]), .out_a(out_a_w[0]), .out_b(out_b_w[0]),
        .redirect_valid(rv_w[0]), .redirect_pc(rpc_w[0]), .occupancy(occ_w[0])
    );

    decode_pipe_stage #(.XLEN(32), .DEPTH(DEPTH), .DELAY_SLOT(0)) u_ds0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .in_pc(in_pc), .in_instr(in_instr), .rs(rs_w[1]), .rt(rt_w[1]),
        .a_gpr(a_gpr), .b_gpr(b_gpr), .ld_busy(ld_busy), .ld_rd(ld_rd), .flush(flush),
        .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_pc(out_pc_w[1]),
        .out_instr(out_instr_w[1]), .out_a(out_a_w[1]), .out_b(out_b_w[1]),
        .redirect_valid(rv_w[1]), .redirect_pc(rpc_w[1]), .occupancy(occ_w[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] imm);
        return {op, imm};
    endfunction

    function automatic logic [31:0] plain(input logic [4:0] s, input logic [4:0] t);
        return {6'b001000, s, t, 16'h0000};
    endfunction

    // Reference branch rules, written as plain arithmetic on the PC.
    function automatic bit ref_branch(input logic [31:0] pc, input logic [31:0] instr,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] tgt);
        logic [31:0] pc4;
        logic [5:0]  op;
        int          off;
        pc4 = pc + 32'd4;
        op  = instr[31:26];
        off = int'($signed(instr[15:0]));
        tgt = 32'd0;
        if (op == 6'd4 || op == 6'd5) begin
            tgt = pc4 + 32'(off * 4);
            return (op == 6'd4) ? (a == b) : (a != b);
        end
        if (op == 6'd2 || op == 6'd3) begin
            tgt = (pc4 & 32'hF000_0000) | (32'(instr[25:0]) << 2);
            return 1'b1;
        end
        if (op == 6'd0 && instr[5:0] == 6'd8) begin
            tgt = a;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Called with inputs stable: check combinational outputs, advance the model.
    task automatic model_step();
        bit          hz;
        bit          taken;
        logic [31:0] tgt;
        ent_t        e;
        hz    = in_valid && ld_busy && (ld_rd != 5'd0) &&
                (ld_rd == in_instr[25:21] || ld_rd == in_instr[20:16]);
        taken = ref_branch(in_pc, in_instr, a_gpr, b_gpr, tgt);
        e     = {in_pc, in_instr, a_gpr, b_gpr};
        for (int i = 0; i < 2; i++) begin
            bit rdy;
            bit acc;
            bit disc;
            bit pop;
            rdy = (m_occ[i] < DEPTH) && !hz;
            chk($sformatf("in_ready[%0d]", i), 64'(in_ready_w[i]), 64'(rdy));
            chk($sformatf("rs[%0d]", i), 64'(rs_w[i]), 64'(in_instr[25:21]));
            chk($sformatf("rt[%0d]", i), 64'(rt_w[i]), 64'(in_instr[20:16]));
            acc  = in_valid && rdy;
            disc = (i == 1) && m_rv[i] && acc;
            pop  = (m_occ[i] != 0) && out_ready;
            if (flush) begin
                m_occ[i] = 0;
                m_rv[i]  = 1'b0;
                if (i == 0) sb0.delete();
                else sb1.delete();
            end else begin
                if (acc && !disc) begin
                    m_occ[i]++;
                    if (i == 0) sb0.push_back(e);
                    else sb1.push_back(e);
                end
                if (pop) m_occ[i]--;
                m_rv[i] = acc && !disc && taken;
                if (m_rv[i]) m_rpc[i] = tgt;
            end
        end
    endtask

    task automatic post_check();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("out_valid[%0d]", i), 64'(out_valid_w[i]), 64'(m_occ[i] != 0));
            chk($sformatf("occupancy[%0d]", i), 64'(occ_w[i]), 64'(m_occ[i]));
            chk($sformatf("redirect_valid[%0d]", i), 64'(rv_w[i]), 64'(m_rv[i]));
            chk($sformatf("redirect_pc[%0d]", i), 64'(rpc_w[i]), 64'(m_rpc[i]));
        end
    endtask

    // One clock: entered and left 2 time units after a rising edge.
    task automatic cyc(input bit iv, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] a, input logic [31:0] b, input bit lb,
                       input logic [4:0] lrd, input bit fl, input bit ordy);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = instr;
        a_gpr     = a;
        b_gpr     = b;
        ld_busy   = lb;
        ld_rd     = lrd;
        flush     = fl;
        out_ready = ordy;
        #1;
        model_step();
        @(posedge clk);
        #1;
        post_check();
        #1;
    endtask

    task automatic idle(input bit ordy);
        cyc(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, ordy);
    endtask

    // Asynchronous reset taken between edges; outputs must clear before the next edge.
    task automatic do_reset();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        ld_busy   = 1'b0;
        rst_n     = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_out_valid[%0d]", i), 64'(out_valid_w[i]), 64'd0);
            chk($sformatf("rst_occupancy[%0d]", i), 64'(occ_w[i]), 64'd0);
            chk($sformatf("rst_redirect_valid[%0d]", i), 64'(rv_w[i]), 64'd0);
            chk($sformatf("rst_redirect_pc[%0d]", i), 64'(rpc_w[i]), 64'd0);
            chk($sformatf("rst_out_pc[%0d]", i), 64'(out_pc_w[i]), 64'd0);
            chk($sformatf("rst_out_instr[%0d]", i), 64'(out_instr_w[i]), 64'd0);
            m_occ[i] = 0;
            m_rv[i]  = 1'b0;
            m_rpc[i] = 32'd0;
        end
        sb0.delete();
        sb1.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic mon_one(input int i);
        ent_t e;
        if (out_valid_w[i] && out_ready) begin
            if ((i == 0 ? sb0.size() : sb1.size()) == 0) begin
                chk($sformatf("pop_without_entry[%0d]", i), 64'd1, 64'd0);
            end else begin
                e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
                chk($sformatf("head_pc[%0d]", i), 64'(out_pc_w[i]), 64'(e.pc));
                chk($sformatf("head_instr[%0d]", i), 64'(out_instr_w[i]), 64'(e.instr));
                chk($sformatf("head_a[%0d]", i), 64'(out_a_w[i]), 64'(e.a));
                chk($sformatf("head_b[%0d]", i), 64'(out_b_w[i]), 64'(e.b));
            end
        end
    endtask

    // Monitor: compare each popped head against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && !flush) begin
            mon_one(0);
            mon_one(1);
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_occ[i] = 0;
            m_rv[i]  = 1'b0;
            m_rpc[i] = 32'd0;
        end
        @(posedge clk);
        #2;
        do_reset();

        // Load-use hazard, then fill to full, then drain in order.
        cyc(1'b1, 32'h0, plain(5'd8, 5'd1), 32'd1, 32'd2, 1'b1, 5'd8, 1'b0, 1'b0);
        cyc(1'b1, 32'h0, plain(5'd0, 5'd1), 32'd3, 32'd4, 1'b1, 5'd0, 1'b0, 1'b0);
        cyc(1'b1, 32'h4, plain(5'd2, 5'd3), 32'd5, 32'd6, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("full_occupancy", 64'(occ_w[0]), 64'd2);
        chk("full_in_ready", 64'(in_ready_w[0]), 64'd0);
        cyc(1'b1, 32'h8, plain(5'd2, 5'd3), 32'd7, 32'd8, 1'b0, 5'd0, 1'b0, 1'b1);
        idle(1'b1);
        chk("drained", 64'(occ_w[0]), 64'd0);

        // BEQ taken then BNE not taken.
        cyc(1'b1, 32'h100, itype(6'd4, 5'd1, 5'd2, 16'h0004), 32'd5, 32'd5, 1'b0, 5'd0, 1'b0, 1'b1);
        chk("beq_redirect_valid", 64'(rv_w[0]), 64'd1);
        chk("beq_redirect_pc", 64'(rpc_w[0]), 64'h114);
        cyc(1'b1, 32'h100, itype(6'd5, 5'd1, 5'd2, 16'h0004), 32'd5, 32'd5, 1'b0, 5'd0, 1'b0, 1'b1);
        chk("bne_redirect_valid", 64'(rv_w[0]), 64'd0);
        chk("bne_redirect_pc_hold", 64'(rpc_w[0]), 64'h114);
        idle(1'b1);
        idle(1'b1);

        // PC wrap-around.
        cyc(1'b1, 32'hF000_0000, jtype(6'd2, 26'h3FF_FFFF), 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        chk("j_wrap_pc", 64'(rpc_w[0]), 64'hFFFF_FFFC);
        idle(1'b1);
        cyc(1'b1, 32'hFFFF_FFFC, itype(6'd4, 5'd0, 5'd0, 16'h0000), 32'd7, 32'd7, 1'b0, 5'd0, 1'b0, 1'b1);
        chk("beq_wrap_valid", 64'(rv_w[0]), 64'd1);
        chk("beq_wrap_pc", 64'(rpc_w[0]), 64'h0);
        idle(1'b1);
        idle(1'b1);

        // Delay-slot discard, then flush with a queue full and with a same-cycle accept.
        cyc(1'b1, 32'h200, jtype(6'd2, 26'h10), 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc(1'b1, 32'h204, plain(5'd1, 5'd1), 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("slot_discard_occ", 64'(occ_w[1]), 64'd1);
        chk("slot_keep_occ", 64'(occ_w[0]), 64'd2);
        cyc(1'b1, 32'h208, plain(5'd1, 5'd1), 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("after_slot_occ", 64'(occ_w[1]), 64'd2);
        cyc(1'b1, 32'h20C, plain(5'd1, 5'd1), 32'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        chk("flush_full_occ", 64'(occ_w[1]), 64'd0);
        cyc(1'b1, 32'h300, itype(6'd4, 5'd1, 5'd1, 16'h0001), 32'd9, 32'd9, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc(1'b1, 32'h304, plain(5'd1, 5'd1), 32'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        chk("flush_accept_occ", 64'(occ_w[0]), 64'd0);
        chk("flush_redirect", 64'(rv_w[0]), 64'd0);

        // Reset while two entries are queued and a redirect is pending.
        cyc(1'b1, 32'h400, plain(5'd1, 5'd2), 32'd1, 32'd2, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc(1'b1, 32'h404, itype(6'd4, 5'd1, 5'd2, 16'h0008), 32'd3, 32'd3, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("pre_reset_occ", 64'(occ_w[0]), 64'd2);
        chk("pre_reset_redirect", 64'(rv_w[0]), 64'd1);
        do_reset();

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            logic [31:0] instr;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  s;
            logic [4:0]  t;
            logic [15:0] imm;
            int          sel;
            if (n == 400) do_reset();
            sel = int'($urandom_range(0, 6));
            s   = 5'($urandom_range(0, 7));
            t   = 5'($urandom_range(0, 7));
            imm = 16'($urandom);
            case (sel)
                0:       instr = itype(6'd4, s, t, imm);
                1:       instr = itype(6'd5, s, t, imm);
                2:       instr = jtype(6'd2, 26'($urandom));
                3:       instr = jtype(6'd3, 26'($urandom));
                4:       instr = {6'd0, s, t, 10'($urandom), 6'd8};
                5:       instr = {6'd0, s, t, 16'($urandom)};
                default: instr = itype(6'd8, s, t, imm);
            endcase
            a = 32'($urandom);
            b = ($urandom_range(0, 1) == 0) ? a : 32'($urandom);
            cyc($urandom_range(0, 9) < 7, 32'($urandom) & 32'hFFFF_FFFC, instr, a, b,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                $urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
